// File: rtl/data_memory_io_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_io_if
// Purpose  : Bundles the CPU data-port bus and the TX byte stream that connect
//            to data_memory_io.
// Signals  : mem_write         CPU write strobe
//            data_memory_addr  CPU byte address
//            write_data        CPU store data
//            read_data         combinational read data back to the CPU
//            tx_data           TX FIFO head byte
//            tx_valid          TX FIFO non-empty
//            tx_ready          consumer accepts the head byte
// Modports : master - CPU / TX consumer side
//            slave  - data_memory_io side
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_io_if;
  logic        mem_write;
  logic [31:0] data_memory_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_write,
    output data_memory_addr,
    output write_data,
    input  read_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  mem_write,
    input  data_memory_addr,
    input  write_data,
    output read_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_io.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_io
// Purpose  : Data-side memory and I/O for a single-cycle CPU. Holds a
//            word-addressed RAM plus a memory-mapped window containing a GPIO
//            register, a byte-wide TX FIFO with valid/ready output and an
//            optional free-running cycle counter. Reads are combinational,
//            writes take effect on the rising clock edge.
// Ports    : clk       system clock, all state updates on rising edge
//            reset     synchronous active-high reset
//            bus       data_memory_io_if.slave (CPU bus + TX stream)
//            gpio_out  8-bit GPIO output register
// Params   : DEPTH       RAM size in 32-bit words (power of two, 16..4096)
//            FIFO_DEPTH  TX FIFO entries (power of two, 2..16)
// Macro    : DATA_MEMORY_IO_CYCLE_COUNTER_EN - when defined the CYCLES
//            register at MMIO offset 0x0C is implemented; otherwise that
//            offset reads 0 and ignores writes.
// Memory map (addr[31:28]):
//            0x0  RAM, word index addr[31:2]; out-of-range reads 0
//            0xF  MMIO, offset addr[7:2]:
//                 0x00 GPIO, 0x04 TX_DATA (write push / read status),
//                 0x08 TX_STATUS {23'b0, overflow, 3'b0, count[4:0]},
//                 0x0C CYCLES
//            else unmapped: reads 0, writes ignored
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_io #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  data_memory_io_if.slave    bus,
  output logic [7:0]         gpio_out
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_AW       = $clog2(DEPTH);
  localparam int          c_PW       = $clog2(FIFO_DEPTH);
  localparam logic [29:0] c_DEPTH    = 30'(DEPTH);
  localparam logic [4:0]  c_FD       = 5'(FIFO_DEPTH);

  localparam logic [3:0]  c_REG_RAM  = 4'h0;
  localparam logic [3:0]  c_REG_MMIO = 4'hF;

  // MMIO word offsets (addr[7:2])
  localparam logic [5:0]  c_OFF_GPIO   = 6'h00;
  localparam logic [5:0]  c_OFF_TXDATA = 6'h01;
  localparam logic [5:0]  c_OFF_STATUS = 6'h02;
  localparam logic [5:0]  c_OFF_CYCLES = 6'h03;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [29:0]     w_word_idx;
  logic            w_is_ram;
  logic            w_is_mmio;
  logic            w_ram_in_range;
  logic [c_AW-1:0] w_ram_idx;
  logic [5:0]      w_mmio_off;

  assign w_word_idx     = bus.data_memory_addr[31:2];
  assign w_is_ram       = (bus.data_memory_addr[31:28] == c_REG_RAM);
  assign w_is_mmio      = (bus.data_memory_addr[31:28] == c_REG_MMIO);
  assign w_ram_in_range = w_is_ram && (w_word_idx < c_DEPTH);
  assign w_ram_idx      = bus.data_memory_addr[c_AW+1:2];
  assign w_mmio_off     = bus.data_memory_addr[7:2];

  // Byte-lane bits are don't-care for a word-only data port.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = &{1'b0, bus.data_memory_addr[1:0]};

  // Write strobes per target
  logic w_ram_wr;
  logic w_gpio_wr;
  logic w_push_req;
  logic w_status_wr;

  assign w_ram_wr    = bus.mem_write && w_ram_in_range;
  assign w_gpio_wr   = bus.mem_write && w_is_mmio && (w_mmio_off == c_OFF_GPIO);
  assign w_push_req  = bus.mem_write && w_is_mmio && (w_mmio_off == c_OFF_TXDATA);
  assign w_status_wr = bus.mem_write && w_is_mmio && (w_mmio_off == c_OFF_STATUS);

  // --------------------------------------------------------------------------
  // RAM: asynchronous read, synchronous write, never cleared by reset
  // --------------------------------------------------------------------------
  logic [31:0] r_ram [DEPTH];

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_ram[w_ram_idx] <= bus.write_data;
    end
  end

  // --------------------------------------------------------------------------
  // GPIO register
  // --------------------------------------------------------------------------
  logic [7:0] r_gpio;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio <= 8'h00;
    end else if (w_gpio_wr) begin
      r_gpio <= bus.write_data[7:0];
    end
  end

  assign gpio_out = r_gpio;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [4:0]      r_count;
  logic            r_overflow;

  logic w_tx_valid;
  logic w_pop;
  logic w_push_ok;

  assign w_tx_valid = (r_count != 5'd0);
  assign w_pop      = w_tx_valid && bus.tx_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign w_push_ok  = w_push_req && ((r_count < c_FD) || w_pop);

  // Storage is not reset; stale entries are unreachable because the
  // pointers and count are.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_fifo[r_wr_ptr] <= bus.write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      // Power-of-two depth: pointer overflow is the modulo wrap.
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end

      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase

      // Push and status write target different offsets, so they never
      // coincide; ordering here is only for readability.
      if (w_push_req && !w_push_ok) begin
        r_overflow <= 1'b1;
      end else if (w_status_wr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Head byte is forced to zero while empty so the reset value is clean.
  assign bus.tx_valid = w_tx_valid;
  assign bus.tx_data  = w_tx_valid ? r_fifo[r_rd_ptr] : 8'h00;

  logic [31:0] w_status;
  assign w_status = {23'b0, r_overflow, 3'b0, r_count};

  // --------------------------------------------------------------------------
  // Cycle counter (optional)
  // --------------------------------------------------------------------------
  logic [31:0] w_cycles_rd;

`ifdef DATA_MEMORY_IO_CYCLE_COUNTER_EN
  logic        w_cycles_wr;
  logic [31:0] r_cycles;

  assign w_cycles_wr = bus.mem_write && w_is_mmio && (w_mmio_off == c_OFF_CYCLES);

  // A load wins over the increment; counting resumes from the loaded value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles <= 32'h0;
    end else if (w_cycles_wr) begin
      r_cycles <= bus.write_data;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign w_cycles_rd = r_cycles;
`else
  assign w_cycles_rd = 32'h0;
`endif

  // --------------------------------------------------------------------------
  // Read mux: pure function of address and current state
  // --------------------------------------------------------------------------
  logic [31:0] w_read_data;

  always_comb begin
    w_read_data = 32'h0;
    if (w_is_ram) begin
      if (w_ram_in_range) begin
        w_read_data = r_ram[w_ram_idx];
      end
    end else if (w_is_mmio) begin
      case (w_mmio_off)
        c_OFF_GPIO:   w_read_data = {24'h0, r_gpio};
        // Reading TX_DATA returns status and never pops.
        c_OFF_TXDATA: w_read_data = w_status;
        c_OFF_STATUS: w_read_data = w_status;
        c_OFF_CYCLES: w_read_data = w_cycles_rd;
        default:      w_read_data = 32'h0;
      endcase
    end
  end

  assign bus.read_data = w_read_data;

endmodule
`default_nettype wire
